// File: rtl/alu16_vector_driver.sv
// alu16_vector_driver
//
// Self-checking vector driver for a 16-bit 74181-based ALU. A 32-bit Galois
// LFSR provides operands while the low six bits of the vector index sweep all
// 64 function/mode/carry combinations. Each vector is held for SETTLE_CYCLES
// cycles. The ALU response is then compared against an internal 74181
// reference model on the edge that leaves CHECK.
//
// Parameters:
//   NUM_VECTORS   vectors per run (1..65535)
//   SETTLE_CYCLES cycles a vector is presented before it is checked (1..255)
//   SEED          LFSR seed; zero is replaced by one
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start            single-cycle run request, honoured only in IDLE/DONE
//   alu_a, alu_b     operands driven to the ALU
//   alu_cin          raw 74181 Cn pin (active-low carry)
//   alu_mode         M pin (1 = logic, 0 = arithmetic)
//   alu_sel          S3..S0
//   alu_result       F returned by the ALU
//   alu_cout         raw Cn+4 returned by the ALU (active-low carry)
//   alu_nbo, alu_ngo group propagate/generate, not checked
//   busy             run in progress
//   done             run finished, held until the next accepted start
//   pass             done with no mismatches
//   err_count        saturating mismatch count
//   first_fail_idx   index of the first mismatching vector
//
// Optional feature (macro ALU16_DRV_STOP_ON_ERR_EN): when defined, the first
// mismatch ends the run and the failing vector stays on the ALU pins.

module alu16_vector_driver #(
    parameter int unsigned NUM_VECTORS   = 1024,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [31:0] SEED          = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_cin,
    output logic        alu_mode,
    output logic [3:0]  alu_sel,
    input  logic [15:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_nbo,
    input  logic        alu_ngo,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_fail_idx
);

    localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] lfsr;
    logic [15:0] idx;
    logic [7:0]  settle_cnt;

    logic [15:0] ref_x;
    logic [15:0] ref_y;
    logic [16:0] ref_sum;
    logic [15:0] ref_f;
    logic        ref_cout;
    logic        mismatch;
    logic        stop_hit;
    logic [15:0] err_next;
    logic [15:0] next_idx;
    logic [31:0] lfsr_step;
    logic        unused_pins;

    // Group carry outputs are intentionally left unchecked.
    assign unused_pins = alu_nbo ^ alu_ngo;

    // 74181 reference for the vector currently on the pins. The carry pins
    // are active-low, so the carry-in is inverted going in and coming out.
    always_comb begin
        ref_x   = alu_a | ({16{alu_sel[0]}} & alu_b) | ({16{alu_sel[1]}} & ~alu_b);
        ref_y   = ({16{alu_sel[3]}} & alu_a & alu_b) | ({16{alu_sel[2]}} & alu_a & ~alu_b);
        ref_sum = {1'b0, ref_x} + {1'b0, ref_y} + {16'b0, ~alu_cin};
        ref_f   = alu_mode ? ~(ref_x ^ ref_y) : ref_sum[15:0];
        ref_cout = ~ref_sum[16];
    end

    // Carry-out only carries meaning in arithmetic mode.
    always_comb begin
        mismatch = (alu_result != ref_f) || (!alu_mode && (alu_cout != ref_cout));
`ifdef ALU16_DRV_STOP_ON_ERR_EN
        stop_hit = mismatch;
`else
        stop_hit = 1'b0;
`endif
    end

    // Next-value helpers: saturating error count, index and LFSR advance.
    always_comb begin
        err_next  = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
        next_idx  = idx + 16'd1;
        lfsr_step = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
    end

    // Run sequencer. The ALU pins are only written on edges that enter
    // SETTLE, so a vector stays stable through its settle and check window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lfsr           <= SEED_EFF;
            idx            <= 16'd0;
            settle_cnt     <= 8'd0;
            alu_a          <= 16'd0;
            alu_b          <= 16'd0;
            alu_cin        <= 1'b0;
            alu_mode       <= 1'b0;
            alu_sel        <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'd0;
            first_fail_idx <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr           <= SEED_EFF;
                        idx            <= 16'd0;
                        alu_a          <= SEED_EFF[31:16];
                        alu_b          <= SEED_EFF[15:0];
                        alu_cin        <= 1'b0;
                        alu_mode       <= 1'b0;
                        alu_sel        <= 4'd0;
                        settle_cnt     <= SETTLE_LOAD;
                        err_count      <= 16'd0;
                        first_fail_idx <= 16'd0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (err_count == 16'd0) begin
                            first_fail_idx <= idx;
                        end
                    end
                    if (stop_hit || (idx == LAST_IDX)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == 16'd0);
                        state <= DONE;
                    end else begin
                        lfsr       <= lfsr_step;
                        idx        <= next_idx;
                        alu_a      <= lfsr_step[31:16];
                        alu_b      <= lfsr_step[15:0];
                        alu_cin    <= next_idx[5];
                        alu_mode   <= next_idx[4];
                        alu_sel    <= next_idx[3:0];
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_vector_driver.sv
// tb_alu16_vector_driver
//
// Bench for alu16_vector_driver with NUM_VECTORS = 64, SETTLE_CYCLES = 2 and
// SEED = 1. A behavioural 74181 (bit-serial ripple form) answers the driver,
// with selectable faults: 0 none, 1 result[0] stuck at 0, 2 carry-out
// inverted in logic mode, 3 carry-out inverted in arithmetic mode.
// Expectations for the stop-on-error build follow ALU16_DRV_STOP_ON_ERR_EN.

module tb_alu16_vector_driver;

    localparam int NV         = 64;
    localparam int SC         = 2;
    localparam int RUN_CYCLES = NV * (SC + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic        alu_mode;
    logic [3:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_fail_idx;

    int fault_mode = 0;
    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] first_run [NV];

    typedef struct {
        int fault;
        int exp_cycles;
        int exp_err;
        bit err_exact;
        bit exp_pass;
        bit check_ffi;
        int exp_ffi;
        bit check_a_held;
    } run_vec_t;

    run_vec_t runs [4];

    alu16_vector_driver #(
        .NUM_VECTORS  (NV),
        .SETTLE_CYCLES(SC),
        .SEED         (32'h0000_0001)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_cin       (alu_cin),
        .alu_mode      (alu_mode),
        .alu_sel       (alu_sel),
        .alu_result    (alu_result),
        .alu_cout      (alu_cout),
        .alu_nbo       (1'b1),
        .alu_ngo       (1'b1),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    // Behavioural ALU with fault injection: ripple carry bit by bit.
    function automatic logic [16:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic cin, input logic mode,
                                              input logic [3:0] s, input int fault);
        logic [15:0] f;
        logic        c;
        logic        x;
        logic        y;
        logic        cout;
        f = 16'd0;
        c = ~cin;
        for (int i = 0; i < 16; i++) begin
            x = a[i] | (s[0] & b[i]) | (s[1] & ~b[i]);
            y = (s[3] & a[i] & b[i]) | (s[2] & a[i] & ~b[i]);
            if (mode) begin
                f[i] = ~(x ^ y);
            end else begin
                f[i] = x ^ y ^ c;
                c    = (x & y) | (x & c) | (y & c);
            end
        end
        cout = ~c;
        if (fault == 1) f[0] = 1'b0;
        if (fault == 2 && mode) cout = ~cout;
        if (fault == 3 && !mode) cout = ~cout;
        return {cout, f};
    endfunction

    assign {alu_cout, alu_result} = alu_model(alu_a, alu_b, alu_cin, alu_mode, alu_sel, fault_mode);

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        if (s[0]) return {1'b0, s[31:1]} ^ 32'h8020_0003;
        return {1'b0, s[31:1]};
    endfunction

    // Single comparison with failure reporting.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Start a run, optionally re-pulse start after edge poke_at, and count
    // edges from the start edge until done (bounded).
    task automatic applyStimulus(input int fault, input int poke_at, output int cycles);
        fault_mode = fault;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
            start = (cycles == poke_at);
        end
        start = 1'b0;
    endtask

    // Walk one full run vector by vector, checking pins against the bench
    // LFSR and either recording or comparing to the first run.
    task automatic traceRun(input bit compare_first);
        logic [31:0] lfsr;
        logic [5:0]  code;
        fault_mode = 0;
        lfsr = 32'h0000_0001;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < NV; k++) begin
            code = 6'(k);
            checkOutput($sformatf("vector %0d pins", k),
                        {26'd0, alu_a, alu_b, alu_cin, alu_mode, alu_sel},
                        {26'd0, lfsr, code});
            if (k == 1) checkOutput("vector 1 operands", {32'd0, alu_a, alu_b}, 64'h8020_0003);
            if (k == 2) checkOutput("vector 2 operands", {32'd0, alu_a, alu_b}, 64'hC030_0002);
            if (compare_first) begin
                checkOutput($sformatf("rerun vector %0d", k), {32'd0, alu_a, alu_b},
                            {32'd0, first_run[k]});
            end else begin
                first_run[k] = {alu_a, alu_b};
            end
            if (k == 0 || k == NV - 1) checkOutput("busy during run", {63'd0, busy}, 64'd1);
            lfsr = lfsr_next(lfsr);
            repeat (SC + 1) @(posedge clk);
            #1;
        end
        checkOutput("trace done", {61'd0, done, busy, pass}, 64'b101);
    endtask

    initial begin
        #200_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        logic [15:0] held_err;

        // Scenario table: fault, cycles to done, errors, exactness, pass,
        // first-fail check, expected index, failing vector held on the pins.
        runs[0] = '{0, RUN_CYCLES, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        runs[2] = '{2, RUN_CYCLES, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
`ifdef ALU16_DRV_STOP_ON_ERR_EN
        runs[1] = '{1, SC + 1, 1, 1'b1, 1'b0, 1'b1, 0, 1'b1};
        runs[3] = '{3, SC + 1, 1, 1'b1, 1'b0, 1'b1, 0, 1'b1};
`else
        runs[1] = '{1, RUN_CYCLES, 1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        runs[3] = '{3, RUN_CYCLES, NV / 2, 1'b1, 1'b0, 1'b1, 0, 1'b0};
`endif

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset alu pins", {26'd0, alu_a, alu_b, alu_cin, alu_mode, alu_sel}, 64'd0);
        checkOutput("reset status", {29'd0, busy, done, pass, err_count, first_fail_idx}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        traceRun(1'b0);

        for (int r = 0; r < 4; r++) begin
            applyStimulus(runs[r].fault, 0, cycles);
            checkOutput($sformatf("run %0d cycles", r), 64'(cycles), 64'(runs[r].exp_cycles));
            if (runs[r].err_exact)
                checkOutput($sformatf("run %0d err_count", r), {48'd0, err_count},
                            64'(runs[r].exp_err));
            else
                checkOutput($sformatf("run %0d err nonzero", r), {63'd0, err_count != 16'd0},
                            64'd1);
            checkOutput($sformatf("run %0d done/busy/pass", r), {61'd0, done, busy, pass},
                        {61'd0, 1'b1, 1'b0, runs[r].exp_pass});
            if (runs[r].check_ffi)
                checkOutput($sformatf("run %0d first_fail_idx", r), {48'd0, first_fail_idx},
                            64'(runs[r].exp_ffi));
            if (runs[r].check_a_held)
                checkOutput($sformatf("run %0d failing vector held", r),
                            {26'd0, alu_a, alu_b, alu_cin, alu_mode, alu_sel},
                            {26'd0, 32'h0000_0001, 6'd0});
            held_err = err_count;
            repeat (5) @(posedge clk);
            #1;
            checkOutput($sformatf("run %0d err stable", r), {48'd0, err_count}, {48'd0, held_err});
            checkOutput($sformatf("run %0d done held", r), {63'd0, done}, 64'd1);
        end

        // A start pulse during SETTLE must not restart or stretch the run.
        applyStimulus(0, SC + 1, cycles);
        checkOutput("start while busy cycles", 64'(cycles), 64'(RUN_CYCLES));
        checkOutput("start while busy result", {45'd0, done, pass, err_count, 1'b0}, {45'd0, 1'b1, 1'b1, 16'd0, 1'b0});

        // Reset during vector 10 aborts everything at once.
        fault_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10 * (SC + 1) + 1) @(posedge clk);
        #1;
        checkOutput("busy before abort", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort alu pins", {26'd0, alu_a, alu_b, alu_cin, alu_mode, alu_sel}, 64'd0);
        checkOutput("abort status", {29'd0, busy, done, pass, err_count, first_fail_idx}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle after abort", {62'd0, busy, done}, 64'd0);

        traceRun(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
